// File: rtl/life_shift_store.sv
// life_shift_store: board storage for a bit-serial Game of Life engine.
// The board is a circular shift register. In RUN it rotates one cell per
// cycle while the neighbour pipeline writes next-generation values back at
// WB_POS. In CLEAR it shifts zeros in for one full rotation. In IDLE the
// board is aligned (pos == 0) and the cell under the cursor can be toggled.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   run                 request continuous generation stepping
//   key_flip            edit key; toggles the cursor cell on its falling edge
//   key_clear           request board clear
//   cursor_x, cursor_y  edit cursor
//   pipe_in             next-generation value from the neighbour pipeline
//   board               registered board, bit y*X+x is cell (x,y)
//   cell_out            board[0], feeds the neighbour pipeline
//   pos                 rotation position within the current generation
//   gen_count           completed generations
//   gen_done            one-cycle pulse after a generation completes
//   busy                state is not IDLE
//   key_flip_d          key_flip delayed one cycle
module life_shift_store #(
  parameter int unsigned X      = 8,
  parameter int unsigned Y      = 8,
  parameter int unsigned LOG2X  = 3,
  parameter int unsigned LOG2Y  = 3,
  parameter int unsigned WB_POS = X * Y - X - 3,
  parameter int unsigned GEN_W  = 16,
  localparam int unsigned N     = X * Y,
  localparam int unsigned PosW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             key_flip,
  input  logic             key_clear,
  input  logic [LOG2X-1:0] cursor_x,
  input  logic [LOG2Y-1:0] cursor_y,
  input  logic             pipe_in,
  output logic [N-1:0]     board,
  output logic             cell_out,
  output logic [PosW-1:0]  pos,
  output logic [GEN_W-1:0] gen_count,
  output logic             gen_done,
  output logic             busy,
  output logic             key_flip_d
);

  localparam logic [PosW-1:0] PosMax = PosW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StClear} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     board_q, board_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic             gen_done_q, gen_done_d;
  logic             kf_dly_q, kf_dly_d;

  logic [31:0]      cx_ext, cy_ext, cell_idx;
  logic             edit_hit;
  logic [N-1:0]     edit_mask;
  logic             pos_wrap;
  logic [PosW-1:0]  pos_nxt;

  // Edit decode: falling edge of key_flip with the cursor inside the board.
  assign cx_ext    = 32'(cursor_x);
  assign cy_ext    = 32'(cursor_y);
  assign cell_idx  = cy_ext * X + cx_ext;
  assign edit_hit  = kf_dly_q && !key_flip && (cx_ext < X) && (cy_ext < Y);
  assign edit_mask = {{(N - 1){1'b0}}, 1'b1} << cell_idx;

  assign pos_wrap = (pos_q == PosMax);
  assign pos_nxt  = pos_wrap ? '0 : pos_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    pos_d       = pos_q;
    gen_count_d = gen_count_q;
    gen_done_d  = 1'b0;
    kf_dly_d    = key_flip;
    case (state_q)
      StIdle: begin
        if (edit_hit) begin
          board_d = board_q ^ edit_mask;
        end
        // Clear wins over run when both are requested.
        if (key_clear) begin
          state_d = StClear;
        end else if (run) begin
          state_d = StRun;
        end
      end
      StRun: begin
        board_d         = {board_q[0], board_q[N-1:1]};
        board_d[WB_POS] = pipe_in;
        pos_d           = pos_nxt;
        if (pos_wrap) begin
          gen_count_d = gen_count_q + 1'b1;
          gen_done_d  = 1'b1;
          // Only leave at a generation boundary so the board stays aligned.
          if (!run) begin
            state_d = StIdle;
          end
        end
      end
      StClear: begin
        board_d = {1'b0, board_q[N-1:1]};
        pos_d   = pos_nxt;
        if (pos_wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      board_q     <= '0;
      pos_q       <= '0;
      gen_count_q <= '0;
      gen_done_q  <= 1'b0;
      kf_dly_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      pos_q       <= pos_d;
      gen_count_q <= gen_count_d;
      gen_done_q  <= gen_done_d;
      kf_dly_q    <= kf_dly_d;
    end
  end

  assign board      = board_q;
  assign cell_out   = board_q[0];
  assign pos        = pos_q;
  assign gen_count  = gen_count_q;
  assign gen_done   = gen_done_q;
  assign busy       = (state_q != StIdle);
  assign key_flip_d = kf_dly_q;

endmodule

// File: tb/tb_life_shift_store.sv
// Bench for life_shift_store: edit table, hand-written multi-cycle
// sequences, a small-board instance for counter wrap, and random stimulus,
// all compared against a cycle-level reference model of the board rules.
module tb_life_shift_store;

  localparam int NC = 64;
  localparam int WB = 53;

  logic        clk = 1'b0;
  logic        reset, run, key_flip, key_clear, pipe_in;
  logic [3:0]  cursor_x, cursor_y;
  logic [63:0] board;
  logic        cell_out, gen_done, busy, key_flip_d;
  logic [5:0]  pos;
  logic [15:0] gen_count;

  // Small instance for the generation counter wrap.
  logic        s_run;
  logic        s_zero;
  logic [3:0]  s_board;
  logic        s_cell, s_done, s_busy, s_kfd;
  logic [1:0]  s_pos;
  logic [3:0]  s_gen;

  always #5 clk = ~clk;

  life_shift_store #(
    .X(8), .Y(8), .LOG2X(4), .LOG2Y(4), .WB_POS(53), .GEN_W(16)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .key_flip(key_flip), .key_clear(key_clear),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .pipe_in(pipe_in), .board(board),
    .cell_out(cell_out), .pos(pos), .gen_count(gen_count), .gen_done(gen_done),
    .busy(busy), .key_flip_d(key_flip_d)
  );

  life_shift_store #(
    .X(2), .Y(2), .LOG2X(1), .LOG2Y(1), .WB_POS(1), .GEN_W(4)
  ) u_small (
    .clk(clk), .reset(reset), .run(s_run), .key_flip(s_zero), .key_clear(s_zero),
    .cursor_x(s_zero), .cursor_y(s_zero), .pipe_in(s_zero), .board(s_board),
    .cell_out(s_cell), .pos(s_pos), .gen_count(s_gen), .gen_done(s_done),
    .busy(s_busy), .key_flip_d(s_kfd)
  );

  int nerr = 0;
  int nchk = 0;

  // Reference model: mode 0 idle, 1 run, 2 clear.
  bit mb[NC];
  int mmode, mpos, mgen;
  bit mdone, mkfd;

  function automatic logic [63:0] mpack();
    logic [63:0] v;
    for (int i = 0; i < NC; i++) v[i] = mb[i];
    return v;
  endfunction

  task automatic model_step(input bit r, input bit rn, input bit kf, input bit kc,
                            input int cx, input int cy, input bit pin);
    bit fall, tmp;
    if (r) begin
      foreach (mb[i]) mb[i] = 1'b0;
      mmode = 0; mpos = 0; mgen = 0; mdone = 0; mkfd = 0;
      return;
    end
    fall  = mkfd && !kf;
    mkfd  = kf;
    mdone = 0;
    if (mmode == 0) begin
      if (fall && cx < 8 && cy < 8) mb[cy * 8 + cx] = !mb[cy * 8 + cx];
      if (kc) mmode = 2;
      else if (rn) mmode = 1;
    end else if (mmode == 1) begin
      tmp = mb[0];
      for (int i = 0; i < NC - 1; i++) mb[i] = mb[i + 1];
      mb[NC - 1] = tmp;
      mb[WB] = pin;
      if (mpos == NC - 1) begin
        mgen  = (mgen + 1) % 65536;
        mdone = 1;
        if (!rn) mmode = 0;
      end
      mpos = (mpos + 1) % NC;
    end else begin
      for (int i = 0; i < NC - 1; i++) mb[i] = mb[i + 1];
      mb[NC - 1] = 1'b0;
      if (mpos == NC - 1) mmode = 0;
      mpos = (mpos + 1) % NC;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check("board", board, mpack());
    check("pos", 64'(pos), 64'(mpos));
    check("gen_count", 64'(gen_count), 64'(mgen));
    check("gen_done", 64'(gen_done), 64'(mdone));
    check("busy", 64'(busy), 64'(mmode != 0));
    check("key_flip_d", 64'(key_flip_d), 64'(mkfd));
    check("cell_out", 64'(cell_out), 64'(mb[0]));
  endtask

  task automatic step(input bit r, input bit rn, input bit kf, input bit kc,
                      input int cx, input int cy, input bit pin);
    reset = r; run = rn; key_flip = kf; key_clear = kc;
    cursor_x = 4'(cx); cursor_y = 4'(cy); pipe_in = pin;
    @(posedge clk);
    model_step(r, rn, kf, kc, cx, cy, pin);
    #1;
    check_all();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit r; bit kf; int cx; int cy;
    bit exp_b10; bit exp_kfd; bit exp_busy;
  } vec_t;

  vec_t vecs[10];

  initial begin
    s_run = 1'b0;
    s_zero = 1'b0;
    mmode = 0; mpos = 0; mgen = 0; mdone = 0; mkfd = 0;

    // Edit table: toggle (2,1) twice, then out-of-range cursors.
    vecs[0] = '{1, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 2, 1, 0, 1, 0};
    vecs[2] = '{0, 0, 2, 1, 1, 0, 0};
    vecs[3] = '{0, 0, 2, 1, 1, 0, 0};
    vecs[4] = '{0, 1, 2, 1, 1, 1, 0};
    vecs[5] = '{0, 0, 2, 1, 0, 0, 0};
    vecs[6] = '{0, 1, 9, 1, 0, 1, 0};
    vecs[7] = '{0, 0, 9, 1, 0, 0, 0};
    vecs[8] = '{0, 1, 3, 9, 0, 1, 0};
    vecs[9] = '{0, 0, 3, 9, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].r, 0, vecs[i].kf, 0, vecs[i].cx, vecs[i].cy, 0);
      check("tbl_b10", 64'(board[10]), 64'(vecs[i].exp_b10));
      check("tbl_kfd", 64'(key_flip_d), 64'(vecs[i].exp_kfd));
      check("tbl_busy", 64'(busy), 64'(vecs[i].exp_busy));
    end
    check("tbl_board_zero", board, 64'd0);

    // Generation counter wrap on the 2x2, 4-bit instance.
    s_run = 1'b1;
    idle_step();
    for (int g = 1; g <= 17; g++) begin
      if (g == 17) s_run = 1'b0;
      for (int k = 0; k < 4; k++) idle_step();
      check("small_gen", 64'(s_gen), 64'(g % 16));
      check("small_done", 64'(s_done), 64'd1);
    end
    check("small_idle", 64'(s_busy), 64'd0);
    idle_step();
    check("small_done_low", 64'(s_done), 64'd0);

    // Single live cell rotated through one generation with pipe_in=0.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rot_seed", board, 64'd1);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 64; k++) begin
      step(0, k < 64, 0, 0, 0, 0, 0);
      if (k == 1) check("rot_b63", 64'(board[63]), 64'd1);
      if (k == 63) check("rot_done_early", 64'(gen_done), 64'd0);
    end
    check("rot_done", 64'(gen_done), 64'd1);
    check("rot_gen", 64'(gen_count), 64'd1);
    check("rot_board", board, 64'd0);
    check("rot_idle", 64'(busy), 64'd0);
    idle_step();
    check("rot_done_pulse", 64'(gen_done), 64'd0);

    // Run dropped after 10 cycles still completes the generation.
    step(0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 64; k++) begin
      step(0, k <= 10, 0, 0, 0, 0, 0);
      if (k < 64) check("stop_busy", 64'(busy), 64'd1);
    end
    check("stop_idle", 64'(busy), 64'd0);
    check("stop_pos", 64'(pos), 64'd0);
    check("stop_gen", 64'(gen_count), 64'd2);

    // Fill the board with ones, then clear with run also requested.
    step(0, 1, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 64; k++) step(0, k < 64, 0, 0, 0, 0, 1);
    check("fill_ones", board, '1);
    step(0, 1, 0, 1, 0, 0, 0);
    check("clr_busy", 64'(busy), 64'd1);
    for (int k = 1; k <= 64; k++) begin
      step(0, 1, 0, 0, 0, 0, 1);
      if (k < 64) check("clr_busy_mid", 64'(busy), 64'd1);
      check("clr_no_done", 64'(gen_done), 64'd0);
    end
    check("clr_board", board, 64'd0);
    check("clr_gen", 64'(gen_count), 64'd3);
    check("clr_idle", 64'(busy), 64'd0);

    // Reset in the middle of a generation.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5 * 64 + 30; k++) step(0, 1, 0, 0, 0, 0, $urandom_range(0, 1));
    check("mid_pos", 64'(pos), 64'd30);
    check("mid_gen", 64'(gen_count), 64'd5);
    step(1, 1, 1, 1, 2, 2, 1);
    check("rst_board", board, 64'd0);
    check("rst_pos", 64'(pos), 64'd0);
    check("rst_gen", 64'(gen_count), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_kfd", 64'(key_flip_d), 64'd0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("post_rst_run", 64'(busy), 64'd1);

    // Random stimulus against the model.
    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
